// File: rtl/lock_key_loader.sv
// lock_key_loader - serial key loader with atomic commit onto a locked netlist's key bus.
// Optional KEY_PARITY_CHECK_EN adds a trailing even-parity bit and the PAR state.
module lock_key_loader #(
  parameter int KEY_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kin_valid,
  input  logic             kin_bit,
  output logic             kin_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(KEY_W - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

`ifdef KEY_PARITY_CHECK_EN
  typedef enum logic [2:0] {IDLE, LOAD, PAR, COMMIT, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, ERR} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [KEY_W-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic             accepting;
  logic             xfer;
  logic             restart;
  logic             timed_out;

`ifdef KEY_PARITY_CHECK_EN
  assign accepting = (state == LOAD) || (state == PAR);
`else
  assign accepting = (state == LOAD);
`endif

  assign kin_ready = accepting;
  assign busy      = accepting;
  assign xfer      = kin_valid & accepting;
  assign timed_out = (timer == TMR_LAST);
  // A start pulse arriving during COMMIT is deliberately dropped.
  assign restart   = start && (state != COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (start) state_next = LOAD;
        else if (xfer) begin
`ifdef KEY_PARITY_CHECK_EN
          if (cnt == CNT_LAST) state_next = PAR;
`else
          if (cnt == CNT_LAST) state_next = COMMIT;
`endif
        end else if (timed_out) state_next = ERR;
      end
`ifdef KEY_PARITY_CHECK_EN
      PAR: begin
        if (start) state_next = LOAD;
        else if (xfer) state_next = ((^shadow) ^ kin_bit) ? ERR : COMMIT;
        else if (timed_out) state_next = ERR;
      end
`endif
      COMMIT: state_next = IDLE;
      ERR: if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      cnt       <= '0;
      timer     <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (restart) begin
      shadow    <= '0;
      cnt       <= '0;
      timer     <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (xfer) begin
        // The parity bit arrives with cnt == KEY_W and so lands in no shadow slot.
        for (int i = 0; i < KEY_W; i++) begin
          if (cnt == CW'(i)) shadow[i] <= kin_bit;
        end
        cnt   <= cnt + CW'(1);
        timer <= '0;
      end else if (accepting) begin
        timer <= timer + TW'(1);
      end
      if (state == COMMIT) begin
        key       <= shadow;
        key_valid <= 1'b1;
      end
      if (state_next == ERR) begin
        key       <= '0;
        key_valid <= 1'b0;
        err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// tb_lock_key_loader - directed plus randomized checks of lock_key_loader against a queue-based model.
module tb_lock_key_loader;

  localparam int KEY_W   = 2;
  localparam int TIMEOUT = 4;
`ifdef KEY_PARITY_CHECK_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NEED = KEY_W + PAR_EN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             kin_valid = 1'b0;
  logic             kin_bit = 1'b0;
  logic             kin_ready;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             busy;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  lock_key_loader #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .kin_valid(kin_valid), .kin_bit(kin_bit),
    .kin_ready(kin_ready), .key(key), .key_valid(key_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 loading (key or parity bits), 2 committing, 3 failed.
  int               m_mode = 0;
  bit               m_q[$];
  int               m_idle = 0;
  logic [KEY_W-1:0] m_key = '0;
  bit               m_kv = 0;
  bit               m_err = 0;

  function automatic bit bits_ok();
    int ones = 0;
    foreach (m_q[i]) ones += m_q[i];
    return (PAR_EN == 0) || (ones % 2 == 0);
  endfunction

  task automatic fail_load();
    m_mode = 3; m_key = '0; m_kv = 0; m_err = 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_q.delete(); m_idle = 0; m_key = '0; m_kv = 0; m_err = 0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin
          m_mode = 1; m_q.delete(); m_idle = 0; m_kv = 0; m_err = 0;
        end
        1: begin
          if (start) begin
            m_q.delete(); m_idle = 0;
          end else if (kin_valid) begin
            m_q.push_back(kin_bit);
            m_idle = 0;
            if (m_q.size() == NEED) begin
              if (bits_ok()) m_mode = 2;
              else fail_load();
            end
          end else begin
            m_idle++;
            if (m_idle == TIMEOUT) fail_load();
          end
        end
        default: begin
          for (int i = 0; i < KEY_W; i++) m_key[i] = m_q[i];
          m_kv = 1; m_mode = 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model key", 32'(key), 32'(m_key));
      chk("model key_valid", 32'(key_valid), 32'(m_kv));
      chk("model err", 32'(err), 32'(m_err));
      chk("model kin_ready", 32'(kin_ready), 32'(m_mode == 1));
      chk("model busy", 32'(busy), 32'(m_mode == 1));
    end
  end

  task automatic cyc(input logic s, input logic v, input logic b);
    start = s; kin_valid = v; kin_bit = b;
    @(negedge clk);
  endtask

  task automatic send(input logic b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic load2(input logic b0, input logic b1);
    cyc(1'b1, 1'b0, 1'b0);
    send(b0);
    send(b1);
    if (PAR_EN != 0) send(b0 ^ b1);
  endtask

  int vprob;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset key", 32'(key), 0);
    chk("reset key_valid", 32'(key_valid), 0);
    chk("reset kin_ready", 32'(kin_ready), 0);
    chk("reset busy", 32'(busy), 0);
    rst = 1'b0;
    chk_en = 1;

    load2(1'b1, 1'b0);
    chk("commit cycle key_valid", 32'(key_valid), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("load 10 key", 32'(key), 32'h1);
    chk("load 10 key_valid", 32'(key_valid), 1);

    cyc(1'b1, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) cyc(1'b0, 1'b0, 1'b0);
    chk("pre-timeout err", 32'(err), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("timeout err", 32'(err), 1);
    chk("timeout key", 32'(key), 0);
    chk("timeout key_valid", 32'(key_valid), 0);
    chk("timeout kin_ready", 32'(kin_ready), 0);

    cyc(1'b1, 1'b0, 1'b0);
    send(1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    send(1'b0);
    send(1'b1);
    if (PAR_EN != 0) send(1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart key", 32'(key), 32'h2);
    chk("restart key_valid", 32'(key_valid), 1);

`ifdef KEY_PARITY_CHECK_EN
    cyc(1'b1, 1'b0, 1'b0);
    send(1'b1); send(1'b1); send(1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("parity good key", 32'(key), 32'h3);
    cyc(1'b1, 1'b0, 1'b0);
    send(1'b1); send(1'b0); send(1'b0);
    chk("parity bad err", 32'(err), 1);
    chk("parity bad key", 32'(key), 0);
`endif

    load2(1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("good key 11", 32'(key), 32'h3);
    cyc(1'b1, 1'b0, 1'b0);
    send(1'b1);
    chk("partial holds key", 32'(key), 32'h3);
    chk("partial key_valid", 32'(key_valid), 0);

    #2 rst = 1'b1;
    #1;
    chk("async rst key", 32'(key), 0);
    chk("async rst key_valid", 32'(key_valid), 0);
    chk("async rst kin_ready", 32'(kin_ready), 0);
    chk("async rst err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    vprob = 60;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: vprob = 0;
          1: vprob = 25;
          2: vprob = 60;
          default: vprob = 100;
        endcase
      end
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
      end
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 99) < vprob), 1'($urandom));
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
